// File: rtl/flasher_mon_pkg.sv
// Shared types and defaults for the LED flasher monitor.
// Holds the monitor state encoding and default widths.
package flasher_mon_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RISE = 2'd1,
        FALL = 2'd2
    } mon_state_t;

endpackage

// File: rtl/thermo_decode.sv
// Thermometer-code decoder: count of lit LEDs plus a
// flag telling whether the vector is a clean thermometer.
module thermo_decode
    import flasher_mon_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0]         led,
    output logic [$clog2(WIDTH+1)-1:0] level,
    output logic                     valid
);

    localparam int LW = $clog2(WIDTH+1);

    logic [WIDTH-1:0] led_inc;

    // 2^n-1 plus one has no bit in common with itself
    assign led_inc = led + WIDTH'(1);
    assign valid   = (led & led_inc) == '0;

    always_comb begin
        level = '0;
        for (int i = 0; i < WIDTH; i++) begin
            level = level + LW'(led[i]);
        end
    end

endmodule

// File: rtl/flasher_monitor.sv
// Watches a thermometer LED flasher: tracks level, rise/fall
// direction, turning points, completed sequences and errors.
module flasher_monitor
    import flasher_mon_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flick,
    input  logic [WIDTH-1:0]           led,
    output logic [$clog2(WIDTH+1)-1:0] level,
    output logic [1:0]                 state,
    output logic                       turn,
    output logic [$clog2(WIDTH+1)-1:0] peak_level,
    output logic [$clog2(WIDTH+1)-1:0] valley_level,
    output logic                       cycle_done,
    output logic [CNT_W-1:0]           cycle_count,
    output logic                       err_pattern,
    output logic                       err_step,
    output logic                       err_start
);

    localparam int LW = $clog2(WIDTH+1);

    logic [WIDTH-1:0] led_q;
    logic [LW-1:0]    n;
    logic             n_ok;
    logic             up;
    logic             dn;
    logic             big;

    mon_state_t       state_q;
    mon_state_t       state_d;
    logic             armed_q;
    logic             armed_d;
    logic [LW-1:0]    level_d;
    logic [LW-1:0]    peak_d;
    logic [LW-1:0]    valley_d;
    logic             turn_d;
    logic             done_d;
    logic [CNT_W-1:0] cnt_d;
    logic             ep_d;
    logic             es_d;
    logic             est_d;

    thermo_decode #(.WIDTH(WIDTH)) u_dec (
        .led   (led_q),
        .level (n),
        .valid (n_ok)
    );

    assign state = state_q;
    assign up    = n > level;
    assign dn    = n < level;
    assign big   = up ? ((n - level) > LW'(1))
                      : ((level - n) > LW'(1));

    always_comb begin
        state_d  = state_q;
        armed_d  = armed_q | ((state_q == IDLE) & flick);
        level_d  = level;
        peak_d   = peak_level;
        valley_d = valley_level;
        turn_d   = 1'b0;
        done_d   = 1'b0;
        cnt_d    = cycle_count;
        ep_d     = err_pattern;
        es_d     = err_step;
        est_d    = err_start;
        if (!n_ok) begin
            ep_d = 1'b1;
        end else if (up || dn) begin
            level_d = n;
            if (big) es_d = 1'b1;
            unique case (state_q)
                IDLE: begin
                    state_d = RISE;
                    if (!armed_q) est_d = 1'b1;
                end
                RISE: begin
                    if (dn) begin
                        turn_d = 1'b1;
                        peak_d = level;
                        if (n == '0) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = FALL;
                        end
                    end
                end
                FALL: begin
                    if (up) begin
                        turn_d   = 1'b1;
                        valley_d = level;
                        state_d  = RISE;
                    end else if (n == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (done_d && (cycle_count != '1)) begin
            cnt_d = cycle_count + CNT_W'(1);
        end
        // a fresh sequence must be kicked again
        if ((state_d == IDLE) && (state_q != IDLE)) begin
            armed_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q        <= '0;
            state_q      <= IDLE;
            armed_q      <= 1'b0;
            level        <= '0;
            peak_level   <= '0;
            valley_level <= '0;
            turn         <= 1'b0;
            cycle_done   <= 1'b0;
            cycle_count  <= '0;
            err_pattern  <= 1'b0;
            err_step     <= 1'b0;
            err_start    <= 1'b0;
        end else begin
            led_q        <= led;
            state_q      <= state_d;
            armed_q      <= armed_d;
            level        <= level_d;
            peak_level   <= peak_d;
            valley_level <= valley_d;
            turn         <= turn_d;
            cycle_done   <= done_d;
            cycle_count  <= cnt_d;
            err_pattern  <= ep_d;
            err_step     <= es_d;
            err_start    <= est_d;
        end
    end

endmodule

// File: tb/tb_flasher_monitor.sv
// Self-checking bench for flasher_monitor: directed scenarios
// plus a random walk checked against a rule-level model.
module tb_flasher_monitor;

    localparam int WIDTH = 16;
    localparam int CNT_W = 3;
    localparam int LW    = $clog2(WIDTH+1);

    logic             clk = 1'b0;
    logic             rst;
    logic             flick;
    logic [WIDTH-1:0] led;
    logic [LW-1:0]    level;
    logic [1:0]       state;
    logic             turn;
    logic [LW-1:0]    peak_level;
    logic [LW-1:0]    valley_level;
    logic             cycle_done;
    logic [CNT_W-1:0] cycle_count;
    logic             err_pattern;
    logic             err_step;
    logic             err_start;

    flasher_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .flick        (flick),
        .led          (led),
        .level        (level),
        .state        (state),
        .turn         (turn),
        .peak_level   (peak_level),
        .valley_level (valley_level),
        .cycle_done   (cycle_done),
        .cycle_count  (cycle_count),
        .err_pattern  (err_pattern),
        .err_step     (err_step),
        .err_start    (err_start)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_turn;
    int n_done;

    // reference model, 0=IDLE 1=RISE 2=FALL
    int m_level, m_state, m_peak, m_valley, m_count;
    bit m_turn, m_done, m_ep, m_es, m_est, m_armed;
    int m_pend;

    function automatic logic [WIDTH-1:0] thermo(input int k);
        logic [WIDTH-1:0] t;
        t = '0;
        for (int i = 0; i < WIDTH; i++) if (i < k) t[i] = 1'b1;
        return t;
    endfunction

    task automatic model_reset();
        m_level = 0; m_state = 0; m_peak = 0; m_valley = 0;
        m_count = 0; m_turn = 0; m_done = 0; m_ep = 0;
        m_es = 0; m_est = 0; m_armed = 0; m_pend = 0;
    endtask

    // one clock edge: judge the sample in flight, take new one
    task automatic model_edge(input bit f, input int l);
        int k;
        bit was_idle;
        k = -1;
        for (int i = 0; i <= WIDTH; i++)
            if (m_pend == (1 << i) - 1) k = i;
        was_idle = (m_state == 0);
        m_turn = 0;
        m_done = 0;
        if (k < 0) begin
            m_ep = 1;
        end else if (k != m_level) begin
            if (k - m_level > 1 || m_level - k > 1) m_es = 1;
            if (m_state == 0) begin
                m_state = 1;
                if (!m_armed) m_est = 1;
            end else if (m_state == 1) begin
                if (k < m_level) begin
                    m_turn = 1;
                    m_peak = m_level;
                    m_state = (k == 0) ? 0 : 2;
                    m_done = (k == 0);
                end
            end else begin
                if (k > m_level) begin
                    m_turn = 1;
                    m_valley = m_level;
                    m_state = 1;
                end else if (k == 0) begin
                    m_state = 0;
                    m_done = 1;
                end
            end
            if (m_done && m_count < (1 << CNT_W) - 1) m_count++;
            m_level = k;
        end
        if (was_idle && f) m_armed = 1;
        if (m_state == 0 && !was_idle) m_armed = 0;
        m_pend = l;
    endtask

    task automatic step(input logic [WIDTH-1:0] l, input bit f);
        @(negedge clk);
        led = l;
        flick = f;
        @(posedge clk);
        model_edge(f, int'(l));
        #1;
        if (turn) n_turn++;
        if (cycle_done) n_done++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        led = '0;
        flick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        n_turn = 0;
        n_done = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (level !== '0) begin
            bad++; $display("FAIL rst_level: got %0d want 0", level);
        end
        total++;
        if (state !== 2'd0) begin
            bad++; $display("FAIL rst_state: got %0d want 0", state);
        end
        total++;
        if ({turn, cycle_done, cycle_count} !== '0) begin
            bad++; $display("FAIL rst_pulse_cnt: got %0d/%0d/%0d want 0",
                            turn, cycle_done, cycle_count);
        end
        total++;
        if ({peak_level, valley_level} !== '0) begin
            bad++; $display("FAIL rst_pv: got %0d/%0d want 0",
                            peak_level, valley_level);
        end
        total++;
        if ({err_pattern, err_step, err_start} !== 3'b000) begin
            bad++; $display("FAIL rst_err: got %b want 000",
                            {err_pattern, err_step, err_start});
        end
        do_reset();
    endtask

    task automatic test_basic();
        do_reset();
        step('0, 1'b1);
        for (int i = 1; i <= 6; i++) step(thermo(i), 1'b0);
        total++;
        if (state !== 2'd1 || level !== LW'(5)) begin
            bad++; $display("FAIL basic_rise: got st=%0d lv=%0d want st=1 lv=5",
                            state, level);
        end
        for (int i = 5; i >= 0; i--) begin
            step(thermo(i), 1'b0);
            if (i == 3) begin
                total++;
                if (state !== 2'd2) begin
                    bad++; $display("FAIL basic_fall: got %0d want 2", state);
                end
            end
        end
        step('0, 1'b0);
        total++;
        if (peak_level !== LW'(6)) begin
            bad++; $display("FAIL basic_peak: got %0d want 6", peak_level);
        end
        total++;
        if (n_turn != 1 || n_done != 1) begin
            bad++; $display("FAIL basic_pulses: got turn=%0d done=%0d want 1/1",
                            n_turn, n_done);
        end
        total++;
        if (cycle_count !== CNT_W'(1) || state !== 2'd0) begin
            bad++; $display("FAIL basic_count: got cnt=%0d st=%0d want 1/0",
                            cycle_count, state);
        end
        total++;
        if ({err_pattern, err_step, err_start} !== 3'b000) begin
            bad++; $display("FAIL basic_err: got %b want 000",
                            {err_pattern, err_step, err_start});
        end
    endtask

    task automatic test_multi_turn();
        do_reset();
        step('0, 1'b1);
        for (int i = 1; i <= 11; i++) step(thermo(i), 1'b0);
        for (int i = 10; i >= 6; i--) step(thermo(i), 1'b0);
        for (int i = 7; i <= 16; i++) step(thermo(i), 1'b0);
        for (int i = 15; i >= 0; i--) step(thermo(i), 1'b0);
        step('0, 1'b0);
        total++;
        if (peak_level !== LW'(16) || valley_level !== LW'(6)) begin
            bad++; $display("FAIL multi_pv: got %0d/%0d want 16/6",
                            peak_level, valley_level);
        end
        total++;
        if (n_turn != 3 || cycle_count !== CNT_W'(1)) begin
            bad++; $display("FAIL multi_turns: got turn=%0d cnt=%0d want 3/1",
                            n_turn, cycle_count);
        end
    endtask

    task automatic test_bad_pattern();
        do_reset();
        step('0, 1'b1);
        step(16'h0001, 1'b0);
        step(16'h0003, 1'b0);
        step(16'h0005, 1'b0);
        step(16'h0007, 1'b0);
        total++;
        if (err_pattern !== 1'b1 || level !== LW'(2)) begin
            bad++; $display("FAIL pat_hold: got ep=%0d lv=%0d want 1/2",
                            err_pattern, level);
        end
        step(16'h0007, 1'b0);
        total++;
        if (level !== LW'(3) || err_step !== 1'b0) begin
            bad++; $display("FAIL pat_next: got lv=%0d es=%0d want 3/0",
                            level, err_step);
        end
    endtask

    task automatic test_step_jump();
        do_reset();
        step('0, 1'b1);
        step(16'h0001, 1'b0);
        step(16'h0003, 1'b0);
        step(16'h001F, 1'b0);
        step(16'h001F, 1'b0);
        total++;
        if (err_step !== 1'b1 || level !== LW'(5) || state !== 2'd1) begin
            bad++; $display("FAIL step_jump: got es=%0d lv=%0d st=%0d want 1/5/1",
                            err_step, level, state);
        end
    endtask

    task automatic test_start();
        do_reset();
        step(16'h0001, 1'b0);
        step(16'h0001, 1'b0);
        total++;
        if (err_start !== 1'b1 || state !== 2'd1) begin
            bad++; $display("FAIL start_nokick: got es=%0d st=%0d want 1/1",
                            err_start, state);
        end
        do_reset();
        step('0, 1'b1);
        step(16'h0001, 1'b0);
        step(16'h0001, 1'b0);
        total++;
        if (err_start !== 1'b0 || state !== 2'd1) begin
            bad++; $display("FAIL start_kick: got es=%0d st=%0d want 0/1",
                            err_start, state);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        step('0, 1'b1);
        for (int i = 1; i <= 12; i++) step(thermo(i), 1'b0);
        for (int i = 11; i >= 9; i--) step(thermo(i), 1'b0);
        step(thermo(9), 1'b0);
        total++;
        if (level !== LW'(9) || state !== 2'd2) begin
            bad++; $display("FAIL mid_pre: got lv=%0d st=%0d want 9/2",
                            level, state);
        end
        @(negedge clk);
        rst = 1'b1;
        led = '0;
        #1;
        total++;
        if ({level, state, peak_level, valley_level} !== '0) begin
            bad++; $display("FAIL mid_rst: got lv=%0d st=%0d pk=%0d vl=%0d want 0",
                            level, state, peak_level, valley_level);
        end
        @(posedge clk);
        #1;
        total++;
        if ({turn, cycle_done, cycle_count} !== '0) begin
            bad++; $display("FAIL mid_rst_cnt: got %0d/%0d/%0d want 0",
                            turn, cycle_done, cycle_count);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        n_turn = 0;
        n_done = 0;
        for (int i = 0; i < 3; i++) step('0, 1'b0);
        total++;
        if (n_turn != 0 || n_done != 0 || cycle_count !== '0) begin
            bad++; $display("FAIL mid_after: got t=%0d d=%0d c=%0d want 0",
                            n_turn, n_done, cycle_count);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int s = 0; s < 9; s++) begin
            step('0, 1'b1);
            step('0, 1'b1);
            step(16'h0001, 1'b0);
            step('0, 1'b0);
        end
        step('0, 1'b0);
        step('0, 1'b0);
        total++;
        if (cycle_count !== CNT_W'(7) || n_done != 9) begin
            bad++; $display("FAIL saturate: got cnt=%0d done=%0d want 7/9",
                            cycle_count, n_done);
        end
        total++;
        if (err_start !== 1'b0 || err_step !== 1'b0) begin
            bad++; $display("FAIL sat_err: got st=%0d sp=%0d want 0/0",
                            err_start, err_step);
        end
    endtask

    task automatic test_random();
        int r;
        int pick;
        logic [WIDTH-1:0] v;
        do_reset();
        r = 0;
        for (int c = 0; c < 600; c++) begin
            pick = int'($urandom_range(0, 99));
            if (pick < 3) begin
                v = WIDTH'($urandom);
            end else begin
                if (pick < 10) r = int'($urandom_range(0, WIDTH));
                else if (pick < 55 && r < WIDTH) r++;
                else if (pick < 95 && r > 0) r--;
                v = thermo(r);
            end
            step(v, $urandom_range(0, 3) == 0);
            total++;
            if (level !== LW'(m_level) || state !== 2'(m_state)) begin
                bad++; $display("FAIL rnd_lvst c=%0d: got %0d/%0d want %0d/%0d",
                                c, level, state, m_level, m_state);
            end
            total++;
            if (turn !== m_turn || cycle_done !== m_done ||
                cycle_count !== CNT_W'(m_count)) begin
                bad++; $display("FAIL rnd_pulse c=%0d: got %0d/%0d/%0d want %0d/%0d/%0d",
                                c, turn, cycle_done, cycle_count,
                                m_turn, m_done, m_count);
            end
            total++;
            if (peak_level !== LW'(m_peak) ||
                valley_level !== LW'(m_valley)) begin
                bad++; $display("FAIL rnd_pv c=%0d: got %0d/%0d want %0d/%0d",
                                c, peak_level, valley_level, m_peak, m_valley);
            end
            total++;
            if ({err_pattern, err_step, err_start} !==
                {m_ep, m_es, m_est}) begin
                bad++; $display("FAIL rnd_err c=%0d: got %b want %b", c,
                                {err_pattern, err_step, err_start},
                                {m_ep, m_es, m_est});
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        flick = 1'b0;
        led = '0;
        model_reset();
        n_turn = 0;
        n_done = 0;
        test_reset();
        test_basic();
        test_multi_turn();
        test_bad_pattern();
        test_step_jump();
        test_start();
        test_mid_reset();
        test_saturate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
